// File: rtl/bayer_mosaic_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : bayer_mosaic_tx_if
// Description : RGB pixel input stream and Bayer raw sample output stream.
// Revision    : 1.0 - initial release
// ============================================================================
interface bayer_mosaic_tx_if;
    logic       s_valid;
    logic       s_ready;
    logic [9:0] s_r;
    logic [9:0] s_g;
    logic [9:0] s_b;
    logic       s_sof;
    logic       s_eol;
    logic       m_valid;
    logic       m_ready;
    logic [9:0] m_data;
    logic       m_sof;
    logic       m_eol;
    logic       m_eof;

    // The re-mosaicer itself: consumes RGB pixels, produces raw samples.
    modport slave (
        input  s_valid, s_r, s_g, s_b, s_sof, s_eol, m_ready,
        output s_ready, m_valid, m_data, m_sof, m_eol, m_eof
    );

    // Environment view: produces RGB pixels, consumes raw samples.
    modport master (
        output s_valid, s_r, s_g, s_b, s_sof, s_eol, m_ready,
        input  s_ready, m_valid, m_data, m_sof, m_eol, m_eof
    );
endinterface
`default_nettype wire

// File: rtl/bayer_mosaic_tx.sv
`default_nettype none
// ============================================================================
// Module      : bayer_mosaic_tx
// Description : Streaming RGB -> Bayer re-mosaicer with one-entry output
//               register. Define MOSAIC_FRAME_CHECK_EN to build the sticky
//               framing checker driving err.
// Revision    : 1.0 - initial release
// ============================================================================
module bayer_mosaic_tx #(
    parameter int IMG_WIDTH     = 640,
    parameter int IMG_HEIGHT    = 480,
    parameter int BAYER_PATTERN = 0
) (
    input  wire logic         clk,
    input  wire logic         rst,
    bayer_mosaic_tx_if.slave  bus,
    output logic              err
);
    localparam int         c_COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int         c_ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
    localparam logic [1:0] c_PHASE = BAYER_PATTERN[1:0];
    localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_WIDTH - 1);
    localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_HEIGHT - 1);

    logic [c_COL_W-1:0] r_col;
    logic [c_ROW_W-1:0] r_row;
    logic               r_m_valid;
    logic [9:0]         r_m_data;
    logic               r_m_sof;
    logic               r_m_eol;
    logic               r_m_eof;

    logic               w_s_ready;
    logic               w_s_xfer;
    logic [c_COL_W-1:0] w_pix_col;
    logic [c_ROW_W-1:0] w_pix_row;
    logic               w_er;
    logic               w_ec;
    logic [9:0]         w_sel;
    logic               w_last_col;
    logic               w_last_row;

    assign w_s_ready = !r_m_valid || bus.m_ready;
    assign w_s_xfer  = bus.s_valid && w_s_ready;

    // s_sof forces the accepted pixel to (0,0) whatever the counters say.
    assign w_pix_col  = bus.s_sof ? '0 : r_col;
    assign w_pix_row  = bus.s_sof ? '0 : r_row;
    assign w_last_col = (w_pix_col == c_COL_LAST);
    assign w_last_row = (w_pix_row == c_ROW_LAST);

    assign w_er = w_pix_row[0] ^ c_PHASE[1];
    assign w_ec = w_pix_col[0] ^ c_PHASE[0];

    always_comb begin
        w_sel = bus.s_g;
        if (!w_er && !w_ec) begin
            w_sel = bus.s_r;
        end else if (w_er && w_ec) begin
            w_sel = bus.s_b;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col     <= '0;
            r_row     <= '0;
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_sof   <= 1'b0;
            r_m_eol   <= 1'b0;
            r_m_eof   <= 1'b0;
        end else if (w_s_xfer) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_sel;
            r_m_sof   <= (w_pix_row == '0) && (w_pix_col == '0);
            r_m_eol   <= w_last_col;
            r_m_eof   <= w_last_col && w_last_row;
            if (w_last_col) begin
                r_col <= '0;
                r_row <= w_last_row ? '0 : w_pix_row + 1'b1;
            end else begin
                r_col <= w_pix_col + 1'b1;
                r_row <= w_pix_row;
            end
        end else if (bus.m_ready) begin
            r_m_valid <= 1'b0;
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.m_valid = r_m_valid;
    assign bus.m_data  = r_m_data;
    assign bus.m_sof   = r_m_sof;
    assign bus.m_eol   = r_m_eol;
    assign bus.m_eof   = r_m_eof;

`ifdef MOSAIC_FRAME_CHECK_EN
    logic r_err;
    logic w_eol_bad;
    logic w_sof_bad;

    // Line end is judged at the post-resync position of the pixel.
    assign w_eol_bad = bus.s_eol != w_last_col;
    assign w_sof_bad = bus.s_sof && ((r_row != '0) || (r_col != '0));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_s_xfer && (w_eol_bad || w_sof_bad)) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_unused_eol;
    assign w_unused_eol = bus.s_eol;
    assign err          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bayer_mosaic_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_bayer_mosaic_tx
// Description : Directed bench for bayer_mosaic_tx, RGGB and BGGR on a 4x2 frame.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bayer_mosaic_tx;
    localparam int c_W = 4;
    localparam int c_H = 2;
`ifdef MOSAIC_FRAME_CHECK_EN
    localparam logic c_ERR_EXP = 1'b1;
`else
    localparam logic c_ERR_EXP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       s_valid = 1'b0;
    logic [9:0] s_r = '0;
    logic [9:0] s_g = '0;
    logic [9:0] s_b = '0;
    logic       s_sof = 1'b0;
    logic       s_eol = 1'b0;
    logic       m_ready = 1'b1;
    logic       err0;
    logic       err1;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;

    bayer_mosaic_tx_if u_if0 ();
    bayer_mosaic_tx_if u_if1 ();

    assign u_if0.s_valid = s_valid;
    assign u_if0.s_r     = s_r;
    assign u_if0.s_g     = s_g;
    assign u_if0.s_b     = s_b;
    assign u_if0.s_sof   = s_sof;
    assign u_if0.s_eol   = s_eol;
    assign u_if0.m_ready = m_ready;
    assign u_if1.s_valid = s_valid;
    assign u_if1.s_r     = s_r;
    assign u_if1.s_g     = s_g;
    assign u_if1.s_b     = s_b;
    assign u_if1.s_sof   = s_sof;
    assign u_if1.s_eol   = s_eol;
    assign u_if1.m_ready = m_ready;

    bayer_mosaic_tx #(.IMG_WIDTH(c_W), .IMG_HEIGHT(c_H), .BAYER_PATTERN(0)) u_rggb (
        .clk (clk), .rst (rst), .bus (u_if0.slave), .err (err0)
    );
    bayer_mosaic_tx #(.IMG_WIDTH(c_W), .IMG_HEIGHT(c_H), .BAYER_PATTERN(3)) u_bggr (
        .clk (clk), .rst (rst), .bus (u_if1.slave), .err (err1)
    );

    // Expected raw sample for stream index n under count-based positioning.
    function automatic logic [9:0] exp_data(input int n, input int pat);
        int row;
        int col;
        int er;
        int ec;
        row = (n / c_W) % c_H;
        col = n % c_W;
        er  = (row & 1) ^ ((pat >> 1) & 1);
        ec  = (col & 1) ^ (pat & 1);
        if (er == 0 && ec == 0) return 10'(32'h100 + n);
        if (er == 1 && ec == 1) return 10'(32'h300 + n);
        return 10'(32'h200 + n);
    endfunction

    task automatic set_pix(input int k, input logic sof, input logic eol);
        s_valid = 1'b1;
        s_r     = 10'(32'h100 + k);
        s_g     = 10'(32'h200 + k);
        s_b     = 10'(32'h300 + k);
        s_sof   = sof;
        s_eol   = eol;
    endtask

    task automatic drive(input int k, input logic sof, input logic eol);
        set_pix(k, sof, eol);
        @(posedge clk);
        #1;
        s_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        m_ready = 1'b0;
        drive(0, 1'b1, 1'b0);
        set_pix(1, 1'b0, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_checks++;
        if ({u_if0.m_valid, u_if0.m_data, u_if0.m_sof, u_if0.m_eol, u_if0.m_eof, err0} !== 15'd0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {u_if0.m_valid, u_if0.m_data, u_if0.m_sof, u_if0.m_eol, u_if0.m_eof, err0});
        end
        n_checks++;
        if (u_if0.s_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL reset_s_ready: got %b expected 1", u_if0.s_ready);
        end
        rst     = 1'b0;
        m_ready = 1'b1;
        drive(5, 1'b0, 1'b0);
        n_checks++;
        if (u_if0.m_valid !== 1'b1 || u_if0.m_sof !== 1'b1 || u_if0.m_data !== 10'h105) begin
            n_errors++;
            $display("FAIL reset_first_pixel: got v=%b sof=%b d=%h expected v=1 sof=1 d=105",
                     u_if0.m_valid, u_if0.m_sof, u_if0.m_data);
        end
        n_checks++;
        if (u_if1.m_data !== 10'h305) begin
            n_errors++;
            $display("FAIL reset_first_bggr: got %h expected 305", u_if1.m_data);
        end
    endtask

    task automatic test_frame();
        logic [9:0] rggb [8];
        logic [9:0] bggr [8];
        rggb = '{10'h100, 10'h201, 10'h102, 10'h203, 10'h204, 10'h305, 10'h206, 10'h307};
        bggr = '{10'h300, 10'h201, 10'h302, 10'h203, 10'h204, 10'h105, 10'h206, 10'h107};
        do_reset();
        n_checks++;
        if (u_if0.m_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL frame_pre_valid: got %b expected 0", u_if0.m_valid);
        end
        for (int k = 0; k < 8; k++) begin
            set_pix(k, k == 0, (k % 4) == 3);
            #1;
            n_checks++;
            if (u_if0.s_ready !== 1'b1) begin
                n_errors++;
                $display("FAIL frame_s_ready k=%0d: got %b expected 1", k, u_if0.s_ready);
            end
            @(posedge clk);
            #1;
            n_checks++;
            if (u_if0.m_valid !== 1'b1 || u_if0.m_data !== rggb[k] || u_if1.m_data !== bggr[k]) begin
                n_errors++;
                $display("FAIL frame_data k=%0d: got v=%b rggb=%h bggr=%h expected v=1 rggb=%h bggr=%h",
                         k, u_if0.m_valid, u_if0.m_data, u_if1.m_data, rggb[k], bggr[k]);
            end
            n_checks++;
            if (u_if0.m_sof !== (k == 0) || u_if0.m_eol !== ((k % 4) == 3) || u_if0.m_eof !== (k == 7)) begin
                n_errors++;
                $display("FAIL frame_flags k=%0d: got sof=%b eol=%b eof=%b expected %b %b %b",
                         k, u_if0.m_sof, u_if0.m_eol, u_if0.m_eof, k == 0, (k % 4) == 3, k == 7);
            end
        end
        s_valid = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (u_if0.m_valid !== 1'b0 || err0 !== 1'b0) begin
            n_errors++;
            $display("FAIL frame_drain: got v=%b err=%b expected 0 0", u_if0.m_valid, err0);
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] pat;
        int   in_idx;
        int   out_idx;
        logic mv;
        logic acc;
        pat     = 4'b1001;
        in_idx  = 0;
        out_idx = 0;
        mv      = 1'b0;
        do_reset();
        for (int c = 0; c < 24; c++) begin
            m_ready = pat[c % 4];
            set_pix(in_idx, (in_idx % 8) == 0, (in_idx % c_W) == c_W - 1);
            #1;
            acc = !mv || m_ready;
            n_checks++;
            if (u_if0.m_valid !== mv || u_if0.s_ready !== acc || u_if1.s_ready !== acc) begin
                n_errors++;
                $display("FAIL bp_handshake c=%0d: got v=%b rdy=%b expected v=%b rdy=%b",
                         c, u_if0.m_valid, u_if0.s_ready, mv, acc);
            end
            if (mv && m_ready) begin
                n_checks++;
                if (u_if0.m_data !== exp_data(out_idx, 0) || u_if1.m_data !== exp_data(out_idx, 3)) begin
                    n_errors++;
                    $display("FAIL bp_data n=%0d: got %h/%h expected %h/%h", out_idx,
                             u_if0.m_data, u_if1.m_data, exp_data(out_idx, 0), exp_data(out_idx, 3));
                end
                out_idx++;
            end
            if (acc) in_idx++;
            mv = acc ? 1'b1 : mv;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (mv) begin
                n_checks++;
                if (u_if0.m_valid !== 1'b1 || u_if0.m_data !== exp_data(out_idx, 0)) begin
                    n_errors++;
                    $display("FAIL bp_drain n=%0d: got v=%b d=%h expected v=1 d=%h",
                             out_idx, u_if0.m_valid, u_if0.m_data, exp_data(out_idx, 0));
                end
                out_idx++;
                mv = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        n_checks++;
        if (out_idx !== in_idx || u_if0.m_valid !== 1'b0 || err0 !== 1'b0) begin
            n_errors++;
            $display("FAIL bp_count: got out=%0d v=%b err=%b expected out=%0d v=0 err=0",
                     out_idx, u_if0.m_valid, err0, in_idx);
        end
    endtask

    task automatic test_resync();
        do_reset();
        for (int k = 0; k < 6; k++) drive(k, k == 0, k == 3);
        n_checks++;
        if (err0 !== 1'b0) begin
            n_errors++;
            $display("FAIL resync_pre_err: got %b expected 0", err0);
        end
        drive(6, 1'b1, 1'b0);
        n_checks++;
        if (u_if0.m_data !== 10'h106 || u_if1.m_data !== 10'h306 || u_if0.m_sof !== 1'b1 || u_if0.m_eol !== 1'b0) begin
            n_errors++;
            $display("FAIL resync_pixel: got %h/%h sof=%b eol=%b expected 106/306 sof=1 eol=0",
                     u_if0.m_data, u_if1.m_data, u_if0.m_sof, u_if0.m_eol);
        end
        n_checks++;
        if (err0 !== c_ERR_EXP || err1 !== c_ERR_EXP) begin
            n_errors++;
            $display("FAIL resync_err: got %b/%b expected %b", err0, err1, c_ERR_EXP);
        end
        drive(7, 1'b0, 1'b0);
        n_checks++;
        if (u_if0.m_data !== 10'h207 || u_if0.m_sof !== 1'b0 || u_if0.m_eol !== 1'b0) begin
            n_errors++;
            $display("FAIL resync_next: got %h sof=%b eol=%b expected 207 sof=0 eol=0",
                     u_if0.m_data, u_if0.m_sof, u_if0.m_eol);
        end
    endtask

    task automatic test_wrong_eol();
        do_reset();
        drive(0, 1'b1, 1'b0);
        drive(1, 1'b0, 1'b0);
        n_checks++;
        if (err0 !== 1'b0) begin
            n_errors++;
            $display("FAIL eol_pre_err: got %b expected 0", err0);
        end
        drive(2, 1'b0, 1'b1);
        n_checks++;
        if (u_if0.m_data !== 10'h102 || u_if1.m_data !== 10'h302 || u_if0.m_eol !== 1'b0 || u_if0.m_eof !== 1'b0) begin
            n_errors++;
            $display("FAIL eol_pixel: got %h/%h eol=%b eof=%b expected 102/302 eol=0 eof=0",
                     u_if0.m_data, u_if1.m_data, u_if0.m_eol, u_if0.m_eof);
        end
        n_checks++;
        if (err0 !== c_ERR_EXP) begin
            n_errors++;
            $display("FAIL eol_err_set: got %b expected %b", err0, c_ERR_EXP);
        end
        drive(3, 1'b0, 1'b1);
        n_checks++;
        if (u_if0.m_data !== 10'h203 || u_if0.m_eol !== 1'b1) begin
            n_errors++;
            $display("FAIL eol_last: got %h eol=%b expected 203 eol=1", u_if0.m_data, u_if0.m_eol);
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (err0 !== c_ERR_EXP) begin
            n_errors++;
            $display("FAIL eol_err_sticky: got %b expected %b", err0, c_ERR_EXP);
        end
        do_reset();
        n_checks++;
        if (err0 !== 1'b0) begin
            n_errors++;
            $display("FAIL eol_err_clear: got %b expected 0", err0);
        end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_backpressure();
        test_resync();
        test_wrong_eol();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/bayer_mosaic_tx.md
# bayer_mosaic_tx

Streaming re-mosaicer: accepts full RGB pixels (10 bits per channel) in raster order and emits one 10-bit Bayer raw sample per pixel, selecting R, G or B by row/column parity and the configured CFA phase. It is the inverse of the demosaic datapath. It is used as the raw-stream source in front of the demosaic pipeline for loopback and regression, and converts RGB test patterns into sensor-format input.

## Interface
- IMG_WIDTH, 640, active pixels per line (≥2)
- IMG_HEIGHT, 480, active lines per frame (≥2)
- BAYER_PATTERN, 0, CFA phase of pixel (0,0): 0=RGGB, 1=GRBG, 2=GBRG, 3=BGGR

- clk  in  1  single clock; all logic rising-edge
- rst  in  1  reset, synchronous, active-high
- s_valid  in  1  input pixel valid
- s_ready  out  1  block can accept input pixel
- s_r, s_g, s_b  in  10 each  input pixel channels
- s_sof  in  1  input pixel is first of frame, (0,0)
- s_eol  in  1  input pixel is last of line
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accepts sample
- m_data  out  10  Bayer raw sample
- m_sof  out  1  sample is (0,0)
- m_eol  out  1  sample is column IMG_WIDTH-1
- m_eof  out  1  sample is (IMG_WIDTH-1, IMG_HEIGHT-1)
- err  out  1  sticky framing error (see Configuration)

## Operation
- Handshake: input transfer occurs when s_valid && s_ready; output transfer occurs when m_valid && m_ready. s_valid must hold, with data stable, until accepted. m_valid/m_data/flags hold stable until accepted.
- Counters: col (0..IMG_WIDTH-1) and row (0..IMG_HEIGHT-1) hold the position of the next accepted pixel. They advance only on an input transfer.
  - col wraps IMG_WIDTH-1→0 and row increments.
  - row wraps IMG_HEIGHT-1→0.
- s_sof resync: an accepted pixel with s_sof=1 is treated as (0,0) regardless of the counters. The next pixel is (0,1).
- s_eol is not used for position. Position is purely count-based; s_eol feeds only the checker.
- Channel select: py = BAYER_PATTERN[1], px = BAYER_PATTERN[0], er = row[0]^py, ec = col[0]^px.
  - er=0, ec=0 → R.
  - er=1, ec=1 → B.
  - otherwise → G.
- Output flags are derived from the position of the accepted pixel, not from the input flags:
  - m_sof = (row==0 && col==0)
  - m_eol = (col==IMG_WIDTH-1)
  - m_eof = m_eol && (row==IMG_HEIGHT-1)
- Data is passed through with no arithmetic, rounding or clipping. m_data is a bit-exact copy of the selected channel.

## Timing
- One-entry output register; s_ready = !m_valid || m_ready (combinational from m_ready and state).
- Latency is 1 cycle: a pixel accepted at edge N drives m_valid and m_data after edge N.
- With m_ready held at 1, throughput is 1 pixel/cycle with no bubbles.
- Backpressure: when m_valid=1 and m_ready=0, s_ready=0 and the register holds. The counters do not move.
- Simultaneous accept-out and accept-in in one cycle: the register reloads with the new sample and m_valid stays 1.
- Reset values:
  - m_valid=0, m_data=0, m_sof=0, m_eol=0, m_eof=0, err=0.
  - col=0, row=0.
  - s_ready=1 in the first cycle after reset.
- Reset mid-frame drops any held sample. The first pixel accepted after reset is (0,0) even without s_sof.
- rst has priority over any transfer in the same cycle.

## Configuration
- MOSAIC_FRAME_CHECK_EN defined: the framing checker is compiled in. On an accepted pixel, err is set and stays set until rst if any of these hold:
  - s_eol=1 at col≠IMG_WIDTH-1.
  - s_eol=0 at col=IMG_WIDTH-1.
  - s_sof=1 while (row,col)≠(0,0).
- In the s_sof case the resync still happens.
- MOSAIC_FRAME_CHECK_EN undefined: err is tied to 0 and no checker logic is present. The datapath is identical in both builds.

## Test plan
- **Reset:** assert rst 2 cycles mid-stream → all outputs 0, s_ready=1; first pixel after release emits with m_sof=1.
- **RGGB 4×2 frame, m_ready=1:** send pixel k as R=0x100+k, G=0x200+k, B=0x300+k → m_data = 0x100, 0x201, 0x102, 0x203, 0x204, 0x305, 0x206, 0x307.
  - 1-cycle latency.
  - m_eol on samples 3 and 7; m_eof on sample 7.
- **BAYER_PATTERN=3 (BGGR), same stimulus** → m_data = 0x300, 0x201, 0x302, 0x203, 0x204, 0x105, 0x206, 0x107.
- **Backpressure:** m_ready = 1,0,0,1 pattern with continuous s_valid → no sample lost or duplicated; s_ready low exactly while m_valid && !m_ready; sequence matches the reference model.
- **Resync:** s_sof on the 3rd pixel of line 1 → that pixel emitted as R with m_sof=1; err=1 only when MOSAIC_FRAME_CHECK_EN is defined, else err=0.
- **Wrong s_eol:** s_eol at col 2 of a 4-wide line → data and flags unchanged; err latches 1 and stays 1 until rst (checker build).
